// File: rtl/card_datapath.sv
// card_datapath: card source, six card registers and hand scoring for the
// baccarat round controller.
//
// Ports:
//   slow_clock        design clock, rising edge
//   resetb            asynchronous active-low reset
//   load_pcard1..3    capture the current card source value into player card 1..3
//   load_dcard1..3    capture the current card source value into dealer card 1..3
//   pcard1..3         player card ranks (0 = empty, 1..13 = A..K)
//   dcard1..3         dealer card ranks
//   pscore, dscore    hand scores 0..9, combinational from the card registers
//   cards_dealt       number of empty registers filled since reset, saturates at 6
//   multi_load_err    sticky: more than one load strobe seen on a single edge
module card_datapath #(
  parameter int unsigned SEED     = 1,
  parameter int unsigned MAX_CARD = 13
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       multi_load_err
);

  localparam int unsigned CARD_W   = 4;
  localparam int unsigned SUM_W    = 5;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned NUM_CARD = 6;
  localparam int unsigned DEALT_W  = CNT_W + 1;

  logic [CARD_W-1:0]                src;
  logic [NUM_CARD-1:0]              load;
  logic [NUM_CARD-1:0][CARD_W-1:0]  card;
  logic [CNT_W-1:0]                 load_cnt;
  logic [CNT_W-1:0]                 new_cnt;
  logic [DEALT_W-1:0]               dealt_sum;
  logic [CNT_W-1:0]                 dealt_nxt;

  // Bit order: player cards 1..3 in bits 0..2, dealer cards 1..3 in bits 3..5.
  assign load = {load_dcard3, load_dcard2, load_dcard1,
                 load_pcard3, load_pcard2, load_pcard1};

  // Count strobes this edge, and those that fill a currently empty register.
  always_comb begin
    load_cnt = '0;
    new_cnt  = '0;
    for (int i = 0; i < NUM_CARD; i++) begin
      if (load[i]) begin
        load_cnt = load_cnt + CNT_W'(1);
        if (card[i] == '0) new_cnt = new_cnt + CNT_W'(1);
      end
    end
    dealt_sum = DEALT_W'(cards_dealt) + DEALT_W'(new_cnt);
    dealt_nxt = (dealt_sum > DEALT_W'(NUM_CARD)) ? CNT_W'(NUM_CARD)
                                                 : dealt_sum[CNT_W-1:0];
  end

  // Free-running card source, card registers and bookkeeping.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      src            <= CARD_W'(SEED);
      card           <= '0;
      cards_dealt    <= '0;
      multi_load_err <= 1'b0;
    end else begin
      src <= (src == CARD_W'(MAX_CARD)) ? CARD_W'(1) : src + CARD_W'(1);
      for (int i = 0; i < NUM_CARD; i++) begin
        if (load[i]) card[i] <= src;
      end
      cards_dealt <= dealt_nxt;
      if (load_cnt > CNT_W'(1)) multi_load_err <= 1'b1;
    end
  end

  assign pcard1 = card[0];
  assign pcard2 = card[1];
  assign pcard3 = card[2];
  assign dcard1 = card[3];
  assign dcard2 = card[4];
  assign dcard3 = card[5];

  // Baccarat value of a rank: 1..9 count as face value, 0 and 10..13 as zero.
  function automatic logic [SUM_W-1:0] card_val(input logic [CARD_W-1:0] rank);
    return (rank >= CARD_W'(1) && rank <= CARD_W'(9)) ? SUM_W'(rank) : '0;
  endfunction

  // Sum of three values is at most 27, so two conditional subtractions suffice.
  function automatic logic [CARD_W-1:0] mod10(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] r;
    if (s >= SUM_W'(20))      r = s - SUM_W'(20);
    else if (s >= SUM_W'(10)) r = s - SUM_W'(10);
    else                      r = s;
    return r[CARD_W-1:0];
  endfunction

  assign pscore = mod10(card_val(card[0]) + card_val(card[1]) + card_val(card[2]));
  assign dscore = mod10(card_val(card[3]) + card_val(card[4]) + card_val(card[5]));

endmodule
